// File: rtl/regfile_clr.sv
// Purpose: MIPS general-purpose register file: one write port, NUM_RD combinational read ports, r0 = 0, write-through bypass, built-in clear sequencer.
// Latency: reads are combinational; writes commit at the next rising edge; a clear takes DEPTH-1 busy cycles followed by one done cycle.
// Backpressure: none; writes presented while the clear is running are dropped, so the CPU stalls on clr_busy.
module regfile_clr #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        wa,
    input  logic [WIDTH-1:0]         wd,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*WIDTH-1:0]  rd,
    input  logic                     clr_req,
    output logic                     clr_busy,
    output logic                     clr_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] CNT_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] CNT_LAST  = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nxt;
    logic [WIDTH-1:0]  mem [DEPTH];

    // Sequencer state and clear pointer; the pointer parks at 1 so it never addresses r0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= CNT_FIRST;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic: IDLE accepts a request, CLEAR walks 1..DEPTH-1, DONE always returns to IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = CNT_FIRST;
                end
            end
            CLEAR: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = DONE;
                    cnt_nxt   = CNT_FIRST;
                end else begin
                    cnt_nxt = cnt + CNT_FIRST;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = CNT_FIRST;
            end
        endcase
    end

    // Storage update: the clear pointer owns the array while clearing, otherwise the write port does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    // Status flags decode straight from the state register, so they cannot glitch.
    assign clr_busy = (state == CLEAR);
    assign clr_done = (state == DONE);

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;

        assign addr = ra[k*ADDR_W +: ADDR_W];

        // Read mux: r0 first, then the in-flight write, then the register being cleared, then storage.
        always_comb begin
            data = mem[addr];
            if (addr == '0) begin
                data = '0;
            end else if ((state != CLEAR) && we && (wa == addr)) begin
                data = wd;
            end else if ((state == CLEAR) && (cnt == addr)) begin
                data = '0;
            end
        end

        assign rd[k*WIDTH +: WIDTH] = data;
    end

endmodule

// File: tb/tb_regfile_clr.sv
module tb_regfile_clr;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // DUT A: default DEPTH=32, NUM_RD=2
    logic        we_a = 1'b0;
    logic [4:0]  wa_a = '0;
    logic [31:0] wd_a = '0;
    logic [9:0]  ra_a = '0;
    logic [63:0] rd_a;
    logic        clr_req_a = 1'b0;
    logic        busy_a;
    logic        done_a;

    // DUT B: DEPTH=16, NUM_RD=3
    logic        we_b = 1'b0;
    logic [3:0]  wa_b = '0;
    logic [31:0] wd_b = '0;
    logic [11:0] ra_b = '0;
    logic [95:0] rd_b;
    logic        clr_req_b = 1'b0;
    logic        busy_b;
    logic        done_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_clr #(.WIDTH(32), .DEPTH(32), .ADDR_W(5), .NUM_RD(2)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we_a),
        .wa       (wa_a),
        .wd       (wd_a),
        .ra       (ra_a),
        .rd       (rd_a),
        .clr_req  (clr_req_a),
        .clr_busy (busy_a),
        .clr_done (done_a)
    );

    regfile_clr #(.WIDTH(32), .DEPTH(16), .ADDR_W(4), .NUM_RD(3)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we_b),
        .wa       (wa_b),
        .wd       (wd_b),
        .ra       (ra_b),
        .rd       (rd_b),
        .clr_req  (clr_req_b),
        .clr_busy (busy_b),
        .clr_done (done_b)
    );

    task automatic test_reset;
        rst_n = 1'b0;
        ra_a  = {5'd3, 5'd0};
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (rd_a[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd0: got %h expected %h", rd_a[31:0], 32'h0);
        end
        checks++;
        if (rd_a[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd1: got %h expected %h", rd_a[63:32], 32'h0);
        end
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags_a: got busy=%b done=%b expected 0 0", busy_a, done_a);
        end
        checks++;
        if (busy_b !== 1'b0 || done_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags_b: got busy=%b done=%b expected 0 0", busy_b, done_b);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_write_bypass;
        @(negedge clk);
        we_a = 1'b1; wa_a = 5'd12; wd_a = 32'h38;
        ra_a = {5'd5, 5'd12};
        #1;
        checks++;
        if (rd_a[31:0] !== 32'h38) begin
            errors++;
            $display("FAIL bypass_rd0: got %h expected %h", rd_a[31:0], 32'h38);
        end
        checks++;
        if (rd_a[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL bypass_other_port: got %h expected %h", rd_a[63:32], 32'h0);
        end
        @(negedge clk);
        we_a = 1'b0;
        #1;
        checks++;
        if (rd_a[31:0] !== 32'h38) begin
            errors++;
            $display("FAIL stored_rd0: got %h expected %h", rd_a[31:0], 32'h38);
        end
    endtask

    task automatic test_reg0;
        @(negedge clk);
        we_a = 1'b1; wa_a = 5'd0; wd_a = 32'hFFFF_FFFF;
        ra_a = {5'd0, 5'd0};
        #1;
        checks++;
        if (rd_a[31:0] !== 32'h0 || rd_a[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL r0_during_write: got %h expected %h", rd_a, 64'h0);
        end
        @(negedge clk);
        we_a = 1'b0;
        #1;
        checks++;
        if (rd_a[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL r0_after_write: got %h expected %h", rd_a[31:0], 32'h0);
        end
    endtask

    task automatic test_full_clear;
        int busy_n;
        int done_n;
        int done_follow;
        logic prev_busy;
        logic [31:0] exp;
        for (int i = 1; i < 32; i++) begin
            @(negedge clk);
            we_a = 1'b1; wa_a = 5'(i); wd_a = 32'hA0 + 32'(i);
        end
        @(negedge clk);
        we_a = 1'b0;
        for (int i = 1; i < 32; i++) begin
            ra_a[4:0] = 5'(i);
            #1;
            checks++;
            if (rd_a[31:0] !== 32'hA0 + 32'(i)) begin
                errors++;
                $display("FAIL fill_readback r%0d: got %h expected %h", i, rd_a[31:0], 32'hA0 + 32'(i));
            end
        end
        @(negedge clk);
        clr_req_a = 1'b1;
        ra_a = {5'd7, 5'd20};
        busy_n = 0; done_n = 0; done_follow = 0; prev_busy = 1'b0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            clr_req_a = 1'b0;
            if (busy_a) begin
                // attempted write during clear must be dropped
                we_a = 1'b1; wa_a = 5'd7; wd_a = 32'hDEAD_BEEF;
                #1;
                exp = (busy_n + 1 >= 20) ? 32'h0 : 32'hB4;
                checks++;
                if (rd_a[31:0] !== exp) begin
                    errors++;
                    $display("FAIL clear_progress_r20 cnt=%0d: got %h expected %h", busy_n + 1, rd_a[31:0], exp);
                end
                exp = (busy_n + 1 >= 7) ? 32'h0 : 32'hA7;
                checks++;
                if (rd_a[63:32] !== exp) begin
                    errors++;
                    $display("FAIL clear_progress_r7 cnt=%0d: got %h expected %h", busy_n + 1, rd_a[63:32], exp);
                end
                if (done_a) done_n++;
                busy_n++;
                prev_busy = 1'b1;
            end else begin
                we_a = 1'b0;
                if (done_a) begin
                    done_n++;
                    if (prev_busy) done_follow++;
                    prev_busy = 1'b0;
                end else if (busy_n > 0) begin
                    break;
                end
            end
        end
        checks++;
        if (busy_n != 31) begin
            errors++;
            $display("FAIL clear_busy_cycles: got %0d expected %0d", busy_n, 31);
        end
        checks++;
        if (done_n != 1 || done_follow != 1) begin
            errors++;
            $display("FAIL clear_done_pulse: got %0d pulses (%0d after busy) expected 1", done_n, done_follow);
        end
        for (int i = 1; i < 32; i++) begin
            ra_a[4:0] = 5'(i);
            #1;
            checks++;
            if (rd_a[31:0] !== 32'h0) begin
                errors++;
                $display("FAIL cleared r%0d: got %h expected %h", i, rd_a[31:0], 32'h0);
            end
        end
    endtask

    task automatic test_reset_midclear;
        int n;
        int seen;
        @(negedge clk);
        we_a = 1'b1; wa_a = 5'd25; wd_a = 32'h77;
        @(negedge clk);
        we_a = 1'b0;
        clr_req_a = 1'b1;
        ra_a = {5'd25, 5'd25};
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            clr_req_a = 1'b0;
            if (busy_a) n++;
            if (n == 10) begin
                rst_n = 1'b0;
                #1;
                break;
            end
        end
        checks++;
        if (n != 10 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL midclear_busy_async: got busy=%b at count %0d expected busy=0 at count 10", busy_a, n);
        end
        checks++;
        if (rd_a[31:0] !== 32'h0) begin
            errors++;
            $display("FAIL midclear_r25: got %h expected %h", rd_a[31:0], 32'h0);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (done_a !== 1'b0 || busy_a !== 1'b0) begin
                errors++;
                $display("FAIL midclear_in_reset: got busy=%b done=%b expected 0 0", busy_a, done_a);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL midclear_after_release: got busy=%b done=%b expected 0 0", busy_a, done_a);
        end
        clr_req_a = 1'b1;
        @(negedge clk);
        clr_req_a = 1'b0;
        #1;
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("FAIL midclear_reaccept: got busy=%b expected 1", busy_a);
        end
        seen = 0;
        for (int c = 0; c < 40 && seen == 0; c++) begin
            @(negedge clk);
            if (done_a) seen = 1;
        end
        checks++;
        if (seen != 1) begin
            errors++;
            $display("FAIL midclear_reclear_done: got %0d expected 1", seen);
        end
    endtask

    task automatic test_depth16;
        int busy_n;
        int done_n;
        int n;
        @(negedge clk);
        we_b = 1'b1; wa_b = 4'd15; wd_b = 32'h1234;
        ra_b = {4'd15, 4'd0, 4'd15};
        #1;
        checks++;
        if (rd_b[95:64] !== 32'h1234 || rd_b[63:32] !== 32'h0) begin
            errors++;
            $display("FAIL b_bypass: got p2=%h p1=%h expected %h %h", rd_b[95:64], rd_b[63:32], 32'h1234, 32'h0);
        end
        @(negedge clk);
        we_b = 1'b0;
        clr_req_b = 1'b1;
        #1;
        checks++;
        if (rd_b[31:0] !== 32'h1234) begin
            errors++;
            $display("FAIL b_stored: got %h expected %h", rd_b[31:0], 32'h1234);
        end
        busy_n = 0; done_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            clr_req_b = 1'b0;
            if (busy_b) busy_n++;
            else if (done_b) done_n++;
            else if (busy_n > 0) break;
        end
        checks++;
        if (busy_n != 15 || done_n != 1) begin
            errors++;
            $display("FAIL b_clear_timing: got busy=%0d done=%0d expected 15 1", busy_n, done_n);
        end
        #1;
        checks++;
        if (rd_b[95:64] !== 32'h0) begin
            errors++;
            $display("FAIL b_cleared_r15: got %h expected %h", rd_b[95:64], 32'h0);
        end
        clr_req_b = 1'b1;
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            clr_req_b = 1'b0;
            if (busy_b) n++;
            if (n == 10) begin
                rst_n = 1'b0;
                #1;
                break;
            end
        end
        checks++;
        if (n != 10 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL b_midclear_busy: got busy=%b at count %0d expected busy=0 at count 10", busy_b, n);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (done_b !== 1'b0 || busy_b !== 1'b0) begin
            errors++;
            $display("FAIL b_midclear_idle: got busy=%b done=%b expected 0 0", busy_b, done_b);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_bypass();
        test_reg0();
        test_full_clear();
        test_reset_midclear();
        test_depth16();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_clr.md
Name: regfile_clr

Overview:
Parameterised general-purpose register file for the MIPS datapath. It has one write port, NUM_RD combinational read ports, register 0 hardwired to zero, and write-through bypass. A built-in clear sequencer zeroes registers 1..DEPTH-1, one per cycle, on request. The sequencer replaces software or bench-driven register scrubbing between programs; the CPU stalls on clr_busy.

Parameters:
WIDTH, 32, data width of each register
DEPTH, 32, number of registers; power of two, >= 4
ADDR_W, 5, address width; must equal log2(DEPTH)
NUM_RD, 2, number of independent read ports

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
we  input  1  write enable
wa  input  ADDR_W  write address
wd  input  WIDTH  write data
ra  input  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd  output  NUM_RD*WIDTH  packed read data; port k uses bits [k*WIDTH +: WIDTH]
clr_req  input  1  clear request, sampled in IDLE
clr_busy  output  1  high while the sequencer is in CLEAR
clr_done  output  1  one-cycle pulse when a clear completes

Behaviour:
- Reset (rst_n low, asynchronous, no clk needed):
  - all registers 0; FSM = IDLE; clear counter = 1; clr_busy = 0; clr_done = 0.
  - rd reflects zeroed contents immediately.
- Register 0:
  - reads always 0; writes to address 0 are discarded and never bypassed.
- Writes:
  - in IDLE or DONE, when we=1 and wa!=0, mem[wa] <= wd at the rising edge (1-cycle write latency).
  - in CLEAR, we is ignored; the write is dropped, not queued.
- Reads: combinational, per port k:
  - ra_k==0 -> 0.
  - else if FSM!=CLEAR, we=1 and wa==ra_k -> wd (bypass).
  - else if FSM==CLEAR and ra_k==counter -> 0 (clear bypass).
  - else -> mem[ra_k].
- FSM states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 -> CLEAR, counter <= 1. A write presented in the same cycle still commits, and is later cleared.
  - CLEAR: each edge, mem[counter] <= 0.
    - counter==DEPTH-1 -> DONE, counter <= 1.
    - else counter <= counter+1.
    - clr_req is ignored.
  - DONE: clr_done=1 for exactly this cycle. Writes are allowed. Next state is IDLE unconditionally; clr_req held high does not retrigger until IDLE samples it.
- Outputs and timing:
  - clr_busy = (FSM==CLEAR), registered state decode, glitch-free.
  - Clear duration: exactly DEPTH-1 cycles busy, then 1 cycle done. Total from accepting edge to IDLE: DEPTH cycles.
  - counter width: ADDR_W; it never wraps past DEPTH-1 and never addresses 0.
- rst_n asserted mid-CLEAR: immediate return to IDLE, all registers 0, and no clr_done pulse.
- All reads are combinational; rd ports are not registered.

Test Plan:
- Reset then read: rst_n low for 2 cycles, then ra={5'd3,5'd0} -> rd=0 on both ports; clr_busy=0, clr_done=0.
- Write/read/bypass: write wa=12, wd=32'h38 with ra0=12 in the same cycle -> rd0=32'h38 before the edge. Next cycle with we=0 -> rd0 still 32'h38.
- Register 0 protection: we=1, wa=0, wd=32'hFFFFFFFF -> ra0=0 reads 0 both during and after the write.
- Full clear (DEPTH=32):
  - Setup: write 1..31 with values 32'hA0+i. Pulse clr_req 1 cycle.
  - clr_busy high for exactly 31 cycles; clr_done high for 1 cycle.
  - Afterwards all ra 1..31 read 0.
  - we=1, wa=7 during busy -> mem[7] stays 0.
- Clear bypass and progression: during CLEAR, read ra0=20.
  - counter<20 -> old value 32'hB4.
  - counter==20 -> 0.
  - thereafter -> 0.
- Reset mid-clear: assert rst_n low at counter=10 -> clr_busy falls asynchronously; no clr_done. After release, FSM is IDLE, all registers 0, and a new clr_req is accepted. Repeat with NUM_RD=3, DEPTH=16: busy for 15 cycles.
